stopwatch_ctrl: RTL

- Control unit for the 4-digit stopwatch datapath: the tick prescaler, the MM:SS BCD counter chain, the display hold registers and the digit multiplexer.
- Debounces the two push-buttons and runs a start/stop/lap/clear state machine.
- Drives the counter-chain enable and clear, the display freeze, and the 2-bit digit-scan select.
- Sits between the board buttons (SW1/SW2) and the counter and display logic in top.

---
 rtl/stopwatch_ctrl_if.sv | 33 +++
 rtl/stopwatch_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
// Bundles the stopwatch controller's button inputs, prescaler pulses and the
// control outputs that go to the counter chain and the display multiplexer.
//   btn_ss, btn_lap : raw push-buttons (asynchronous, active-high)
//   tick, scan_tick : one-cycle pulses from the prescalers
//   cnt_en, cnt_clr : counter-chain enable / synchronous clear
//   disp_hold       : 1 = display registers freeze
//   state           : IDLE=00, RUN=01, STOP=10, LAP=11
//   scan_sel        : digit-scan select 0..3
// Modports: master = the controller, slave = the board/counter side.
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_lap;
  logic       tick;
  logic       scan_tick;
  logic       cnt_en;
  logic       cnt_clr;
  logic       disp_hold;
  logic [1:0] state;
  logic [1:0] scan_sel;

  modport master (
    input  btn_ss, btn_lap, tick, scan_tick,
    output cnt_en, cnt_clr, disp_hold, state, scan_sel
  );

  modport slave (
    output btn_ss, btn_lap, tick, scan_tick,
    input  cnt_en, cnt_clr, disp_hold, state, scan_sel
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Control unit of the 4-digit MM:SS stopwatch. Synchronises and debounces the
// start/stop and lap/clear buttons, runs the IDLE/RUN/STOP/LAP state machine
// and drives the counter-chain enable/clear, the display freeze and the
// digit-scan select.
//   clk : system clock, all logic on posedge
//   rst : synchronous reset, active-low
//   sw  : stopwatch_ctrl_if.master (buttons, tick pulses, control outputs)
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = $clog2(DB_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.master sw
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_e;

  // Bit 0 = start/stop button, bit 1 = lap/clear button.
  logic [1:0]            btn_s;
  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0]            db_q;
  logic [1:0]            db_d;
  logic [1:0]            db_prev_q;
  logic [1:0][DB_W-1:0]  cnt_q;
  logic [1:0][DB_W-1:0]  cnt_d;
  logic [1:0]            press_s;

  state_e                state_q;
  state_e                state_d;
  logic                  cnt_clr_q;
  logic                  disp_hold_q;
  logic [1:0]            scan_sel_q;

  assign btn_s = {sw.btn_lap, sw.btn_ss};

  // Two-flop synchronisers for both raw buttons.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= btn_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: the level only follows the synchronised input after
  // DB_CYCLES consecutive cycles of disagreement; any agreement restarts it.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == db_q[b]) begin
        cnt_d[b] = {DB_W{1'b0}};
      end else if (cnt_q[b] == DB_W'(DB_CYCLES - 1)) begin
        db_d[b]  = sync2_q[b];
        cnt_d[b] = {DB_W{1'b0}};
      end else begin
        cnt_d[b] = cnt_q[b] + DB_W'(1);
      end
    end
  end

  // Debounce registers, plus the delayed copy used for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_q      <= 2'b00;
      db_prev_q <= 2'b00;
      cnt_q     <= {2{{DB_W{1'b0}}}};
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  // One-cycle press events on 0->1 of the debounced level; release ignored.
  assign press_s = db_q & ~db_prev_q;

  // Next-state decode; start/stop has priority when both events coincide.
  always_comb begin
    state_d = state_q;
    if (press_s[0]) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = STOP;
        LAP:     state_d = STOP;
        STOP:    state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (press_s[1]) begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = LAP;
        LAP:     state_d = RUN;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State register with its registered outputs. The clear pulse is the one
  // cycle after STOP->IDLE; the rst path leaves it low since the counters
  // reset themselves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_clr_q   <= 1'b0;
      disp_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_clr_q   <= (state_q == STOP) && (state_d == IDLE);
      disp_hold_q <= (state_d == LAP);
    end
  end

  // Digit-scan select free-runs modulo 4 in every state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_sel_q <= 2'b00;
    end else if (sw.scan_tick) begin
      scan_sel_q <= scan_sel_q + 2'b01;
    end else begin
      scan_sel_q <= scan_sel_q;
    end
  end

  // cnt_en is deliberately combinational so a tick reaches the counters in
  // the same cycle; counting continues while the display is frozen in LAP.
  assign sw.cnt_en    = sw.tick & ((state_q == RUN) | (state_q == LAP));
  assign sw.cnt_clr   = cnt_clr_q;
  assign sw.disp_hold = disp_hold_q;
  assign sw.state     = state_q;
  assign sw.scan_sel  = scan_sel_q;

endmodule
